cvxif_offload_tracker: RTL

- Tracks instructions offloaded from the issue stage to a CV-X-IF coprocessor. Up to NR_ENTRIES can be outstanding at once.
- Forwards each request to the coprocessor over a valid/ready channel, matches returning results by entry index, and writes them back to the scoreboard one cycle later.
- Discards results for instructions killed by a flush.
- When the coprocessor interface is disabled, it answers every offload itself with an illegal-instruction writeback.

---
 rtl/cvxif_tracker_pkg.sv | 35 +++
 rtl/cvxif_free_finder.sv | 29 ++
 rtl/cvxif_offload_tracker.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cvxif_tracker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cvxif_tracker_pkg                                                    |
// | Shared types and default configuration for the CV-X-IF offload       |
// | tracker.                                                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cvxif_tracker_pkg;

  localparam int unsigned CVXIF_XLEN          = 64;
  localparam int unsigned CVXIF_NR_ENTRIES    = 4;
  localparam int unsigned CVXIF_TRANS_ID_BITS = 3;
  localparam int unsigned CVXIF_ID_BITS       = $clog2(CVXIF_NR_ENTRIES);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    SENT    = 2'd2
  } entry_state_e;

  typedef struct packed {
    entry_state_e                   state;
    logic                           killed;
    logic [CVXIF_TRANS_ID_BITS-1:0] trans_id;
  } entry_t;

  typedef struct packed {
    logic [CVXIF_ID_BITS-1:0] id;
    logic [31:0]              instr;
    logic [CVXIF_XLEN-1:0]    rs1;
    logic [CVXIF_XLEN-1:0]    rs2;
  } req_t;

endpackage
`default_nettype wire

// File: rtl/cvxif_free_finder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cvxif_free_finder                                                    |
// | Combinational lowest-index FREE slot finder.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cvxif_free_finder #(
  parameter  int unsigned NR_ENTRIES = 4,
  localparam int unsigned ID_BITS    = $clog2(NR_ENTRIES)
) (
  input  logic [NR_ENTRIES-1:0] i_free,
  output logic [ID_BITS-1:0]    o_idx,
  output logic                  o_found
);

  // Scanning downward lets the lowest set bit win.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (i_free[i]) begin
        o_idx   = ID_BITS'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cvxif_offload_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cvxif_offload_tracker                                                |
// | Tracks instructions offloaded to a CV-X-IF coprocessor and writes    |
// | their results back to the scoreboard.                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cvxif_offload_tracker
  import cvxif_tracker_pkg::*;
#(
  parameter  int unsigned XLEN          = CVXIF_XLEN,
  parameter  int unsigned NR_ENTRIES    = CVXIF_NR_ENTRIES,
  parameter  int unsigned TRANS_ID_BITS = CVXIF_TRANS_ID_BITS,
  parameter  bit          CVXIF_EN      = 1'b1,
  localparam int unsigned ID_BITS       = $clog2(NR_ENTRIES)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
  input  logic [31:0]              issue_instr_i,
  input  logic [XLEN-1:0]          issue_rs1_i,
  input  logic [XLEN-1:0]          issue_rs2_i,
  output logic                     cop_req_valid_o,
  input  logic                     cop_req_ready_i,
  output logic [ID_BITS-1:0]       cop_req_id_o,
  output logic [31:0]              cop_req_instr_o,
  output logic [XLEN-1:0]          cop_req_rs1_o,
  output logic [XLEN-1:0]          cop_req_rs2_o,
  input  logic                     cop_res_valid_i,
  output logic                     cop_res_ready_o,
  input  logic [ID_BITS-1:0]       cop_res_id_i,
  input  logic [XLEN-1:0]          cop_res_data_i,
  input  logic                     cop_res_exc_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_data_o,
  output logic                     wb_exc_o,
  output logic                     busy_o,
  output logic                     proto_err_o
);

  assign cop_res_ready_o = 1'b1;

  generate
    if (CVXIF_EN) begin : g_cvxif_on
      entry_t                   r_entries [NR_ENTRIES];
      req_t                     r_req;
      logic                     r_req_valid;
      logic                     r_wb_valid;
      logic [TRANS_ID_BITS-1:0] r_wb_trans_id;
      logic [XLEN-1:0]          r_wb_data;
      logic                     r_wb_exc;
      logic                     r_proto_err;

      logic [NR_ENTRIES-1:0]    w_free;
      logic [ID_BITS-1:0]       w_alloc_idx;
      logic                     w_found;
      logic                     w_issue_fire;
      logic                     w_req_fire;
      entry_t                   w_res_entry;
      logic                     w_res_accept;
      logic                     w_res_wb;

      for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_free_vec
        assign w_free[gi] = (r_entries[gi].state == FREE);
      end

      cvxif_free_finder #(
        .NR_ENTRIES(NR_ENTRIES)
      ) u_free_finder (
        .i_free (w_free),
        .o_idx  (w_alloc_idx),
        .o_found(w_found)
      );

      assign issue_ready_o = !flush_i && w_found && (!r_req_valid || cop_req_ready_i);
      assign w_issue_fire  = issue_valid_i && issue_ready_o;
      assign w_req_fire    = r_req_valid && cop_req_ready_i;

      // A result may race its own request handshake; that entry is still PENDING.
      assign w_res_entry  = r_entries[cop_res_id_i];
      assign w_res_accept = cop_res_valid_i &&
                            ((w_res_entry.state == SENT) ||
                             ((w_res_entry.state == PENDING) && w_req_fire &&
                              (r_req.id == cop_res_id_i)));
      assign w_res_wb     = w_res_accept && !w_res_entry.killed && !flush_i;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < NR_ENTRIES; i++) begin
            r_entries[i] <= '{state: FREE, killed: 1'b0, trans_id: '0};
          end
        end else begin
          for (int i = 0; i < NR_ENTRIES; i++) begin
            if (w_issue_fire && (w_alloc_idx == ID_BITS'(i))) begin
              r_entries[i] <= '{state: PENDING, killed: 1'b0, trans_id: issue_trans_id_i};
            end else begin
              if (w_res_accept && (cop_res_id_i == ID_BITS'(i))) begin
                r_entries[i].state <= FREE;
              end else if (w_req_fire && (r_req.id == ID_BITS'(i))) begin
                r_entries[i].state <= SENT;
              end
              if (flush_i && (r_entries[i].state != FREE)) begin
                r_entries[i].killed <= 1'b1;
              end
            end
          end
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_req       <= '0;
          r_req_valid <= 1'b0;
        end else if (w_issue_fire) begin
          r_req       <= '{id: w_alloc_idx, instr: issue_instr_i,
                           rs1: issue_rs1_i, rs2: issue_rs2_i};
          r_req_valid <= 1'b1;
        end else if (w_req_fire) begin
          r_req_valid <= 1'b0;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_wb_valid    <= 1'b0;
          r_wb_trans_id <= '0;
          r_wb_data     <= '0;
          r_wb_exc      <= 1'b0;
          r_proto_err   <= 1'b0;
        end else begin
          r_wb_valid <= w_res_wb;
          if (w_res_wb) begin
            r_wb_trans_id <= w_res_entry.trans_id;
            r_wb_data     <= cop_res_data_i;
            r_wb_exc      <= cop_res_exc_i;
          end
          if (cop_res_valid_i && !w_res_accept) begin
            r_proto_err <= 1'b1;
          end
        end
      end

      assign cop_req_valid_o = r_req_valid;
      assign cop_req_id_o    = r_req.id;
      assign cop_req_instr_o = r_req.instr;
      assign cop_req_rs1_o   = r_req.rs1;
      assign cop_req_rs2_o   = r_req.rs2;
      assign wb_valid_o      = r_wb_valid;
      assign wb_trans_id_o   = r_wb_trans_id;
      assign wb_data_o       = r_wb_data;
      assign wb_exc_o        = r_wb_exc;
      assign busy_o          = ~&w_free;
      assign proto_err_o     = r_proto_err;
    end else begin : g_cvxif_off
      logic                     r_wb_valid;
      logic [TRANS_ID_BITS-1:0] r_wb_trans_id;
      logic                     w_unused;

      assign issue_ready_o = !flush_i;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_wb_valid    <= 1'b0;
          r_wb_trans_id <= '0;
        end else begin
          r_wb_valid <= issue_valid_i && issue_ready_o;
          if (issue_valid_i && issue_ready_o) begin
            r_wb_trans_id <= issue_trans_id_i;
          end
        end
      end

      assign w_unused = ^{cop_req_ready_i, cop_res_valid_i, cop_res_id_i, cop_res_data_i,
                          cop_res_exc_i, issue_instr_i, issue_rs1_i, issue_rs2_i};

      assign cop_req_valid_o = 1'b0;
      assign cop_req_id_o    = '0;
      assign cop_req_instr_o = '0;
      assign cop_req_rs1_o   = '0;
      assign cop_req_rs2_o   = '0;
      assign wb_valid_o      = r_wb_valid;
      assign wb_trans_id_o   = r_wb_trans_id;
      assign wb_data_o       = '0;
      assign wb_exc_o        = r_wb_valid;
      assign busy_o          = 1'b0;
      assign proto_err_o     = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire
